// File: rtl/hazard_detect.sv
// Execute-stage forwarding producer: 2-slot destination scoreboard, registered
// rs1/rs2 forwarding codes, store-after-load flag and a single-cycle load-use stall.
module hazard_detect #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  id_is_store,
    input  logic                  flush,
    output logic [1:0]            rs1_hazard,
    output logic [1:0]            rs2_hazard,
    output logic                  store_load_hazard,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  is_load;
    } slot_t;

    typedef enum logic {RUN, STALL} state_t;

    slot_t  ex_slot, wb_slot;
    state_t state, next_state;

    logic       ex_m1, ex_m2, wb_m1, wb_m2;
    logic [1:0] rs1_code, rs2_code;
    logic       load_use, store_load, advance;

    // x0 and unread sources never match, so a nop or x0 write cannot forward
    always_comb begin
        ex_m1 = ex_slot.valid & ex_slot.regwrite & (ex_slot.rd == id_rs1) &
                (id_rs1 != '0) & id_uses_rs1;
        ex_m2 = ex_slot.valid & ex_slot.regwrite & (ex_slot.rd == id_rs2) &
                (id_rs2 != '0) & id_uses_rs2;
        wb_m1 = wb_slot.valid & wb_slot.regwrite & (wb_slot.rd == id_rs1) &
                (id_rs1 != '0) & id_uses_rs1;
        wb_m2 = wb_slot.valid & wb_slot.regwrite & (wb_slot.rd == id_rs2) &
                (id_rs2 != '0) & id_uses_rs2;

        rs1_code = ex_m1 ? 2'b01 : (wb_m1 ? 2'b10 : 2'b00);
        rs2_code = ex_m2 ? 2'b01 : (wb_m2 ? 2'b10 : 2'b00);

        load_use   = ex_slot.is_load & (ex_m1 | (ex_m2 & ~id_is_store));
        store_load = id_is_store & ex_slot.is_load & ex_m2;
    end

    always_comb begin
        next_state = RUN;
        stall      = 1'b0;
        unique case (state)
            RUN: begin
                stall = id_valid & load_use & ~flush;
                if (stall)
                    next_state = STALL;
            end
            STALL: next_state = RUN;
            default: next_state = RUN;
        endcase
        advance = id_valid & ~stall & ~flush;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= RUN;
        else
            state <= next_state;
    end

    // A store whose data comes from the load in EX takes it from the load
    // path directly, so its rs2 code is suppressed in favour of the flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_slot           <= '0;
            wb_slot           <= '0;
            rs1_hazard        <= '0;
            rs2_hazard        <= '0;
            store_load_hazard <= 1'b0;
            stall_cnt         <= '0;
        end else begin
            wb_slot   <= ex_slot;
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall};
            if (advance) begin
                ex_slot           <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite,
                                       is_load: id_is_load};
                rs1_hazard        <= rs1_code;
                rs2_hazard        <= store_load ? 2'b00 : rs2_code;
                store_load_hazard <= store_load;
            end else begin
                ex_slot           <= '0;
                rs1_hazard        <= '0;
                rs2_hazard        <= '0;
                store_load_hazard <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_detect.sv
// Scoreboard bench for hazard_detect: directed program fragments plus random
// decode traffic, checked against a producer-distance reference model.
module tb_hazard_detect;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic          id_regwrite = 1'b0, id_is_load = 1'b0, id_is_store = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    rs1_hazard, rs2_hazard;
    logic          store_load_hazard, stall;
    logic [CW-1:0] stall_cnt;

    hazard_detect #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_is_store(id_is_store), .flush(flush),
        .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
        .store_load_hazard(store_load_hazard), .stall(stall),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid, u1, u2, rw, ld, st, fl;
        logic [RW-1:0] rs1, rs2, rd;
    } instr_t;

    typedef struct {
        logic          stall;
        logic [1:0]    r1, r2;
        logic          slh;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // reference model: what entered EX one and two cycles ago
    instr_t dist1, dist2;
    logic   was_stall;
    int     exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic writes(instr_t p, logic [RW-1:0] s, logic u);
        return p.valid && p.rw && (p.rd == s) && (s != 0) && u;
    endfunction

    function automatic logic [1:0] fwd(logic [RW-1:0] s, logic u);
        if (writes(dist1, s, u)) return 2'd1;
        if (writes(dist2, s, u)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic instr_t mk(logic v, logic [RW-1:0] rs1, logic u1, logic [RW-1:0] rs2,
                                  logic u2, logic [RW-1:0] rd, logic rw, logic ld, logic st,
                                  logic fl);
        instr_t i;
        i.valid = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        i.rd = rd; i.rw = rw; i.ld = ld; i.st = st; i.fl = fl;
        return i;
    endfunction

    function automatic instr_t nop_i();
        return mk(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic model_clear();
        dist1 = nop_i(); dist2 = nop_i();
        was_stall = 1'b0; exp_cnt = 0;
    endtask

    task automatic cycle(input instr_t i);
        exp_t   e;
        logic   dep_ld1, dep_ld2, adv, sl;
        @(negedge clk);
        rstn = 1'b1;
        id_valid = i.valid; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_rd = i.rd;
        id_regwrite = i.rw; id_is_load = i.ld; id_is_store = i.st; flush = i.fl;
        #1;
        dep_ld1 = dist1.ld && writes(dist1, i.rs1, i.u1);
        dep_ld2 = dist1.ld && writes(dist1, i.rs2, i.u2);
        sl      = i.st && dep_ld2;
        e.stall = i.valid && !i.fl && !was_stall && (dep_ld1 || (dep_ld2 && !i.st));
        adv     = i.valid && !i.fl && !e.stall;
        e.r1    = adv ? fwd(i.rs1, i.u1) : 2'd0;
        e.r2    = (adv && !sl) ? fwd(i.rs2, i.u2) : 2'd0;
        e.slh   = adv && sl;
        exp_cnt = (exp_cnt + (e.stall ? 1 : 0)) % (1 << CW);
        e.cnt   = exp_cnt[CW-1:0];
        sb.push_back(e);
        dist2     = dist1;
        dist1     = adv ? i : nop_i();
        was_stall = e.stall;
    endtask

    // decode holds a stalled instruction and presents it again
    task automatic issue(input instr_t i);
        cycle(i);
        while (was_stall) cycle(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        id_valid = 1'b0; flush = 1'b0;
        #1;
        chk("rst_rs1", {30'd0, rs1_hazard}, 0);
        chk("rst_rs2", {30'd0, rs2_hazard}, 0);
        chk("rst_slh", {31'd0, store_load_hazard}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_cnt", {28'd0, stall_cnt}, 0);
        model_clear();
    endtask

    // monitor: combinational stall mid-cycle, registered outputs after the edge
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, r.stall});
                @(posedge clk);
                #1;
                chk("rs1_hazard", {30'd0, rs1_hazard}, {30'd0, r.r1});
                chk("rs2_hazard", {30'd0, rs2_hazard}, {30'd0, r.r2});
                chk("store_load", {31'd0, store_load_hazard}, {31'd0, r.slh});
                chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, r.cnt});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t cur;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // add x5,x1,x2 ; add x6,x5,x3
        issue(mk(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0));
        issue(mk(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0));
        // add x5 ; nop ; sub x7,x0,x5 ; add x0 ; reader of x0
        issue(mk(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0));
        issue(nop_i());
        issue(mk(1, 5'd0, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0));
        issue(mk(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0));
        issue(mk(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0));

        // lw x8,0(x1) ; add x9,x8,x8
        do_reset();
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        issue(mk(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0, 0));
        chk("lu_cnt_one", {28'd0, stall_cnt}, 1);
        // lw x8 ; sw x8,4(x2)  then  lw x8 ; sw x3,0(x8)
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        issue(mk(1, 5'd2, 1, 5'd8, 1, 5'd0, 0, 0, 1, 0));
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        issue(mk(1, 5'd8, 1, 5'd3, 1, 5'd0, 0, 0, 1, 0));
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        issue(mk(1, 5'd8, 1, 5'd8, 1, 5'd0, 0, 0, 1, 0));
        chk("store_lu_cnt", {28'd0, stall_cnt}, 3);

        // load-use with flush in the would-be stall cycle
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        issue(mk(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0, 1));
        issue(nop_i());
        chk("flush_cnt", {28'd0, stall_cnt}, 3);

        // reset while in STALL, then a fresh load-use must still stall
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        cycle(mk(1, 5'd8, 1, 5'd2, 1, 5'd9, 1, 0, 0, 0));
        do_reset();
        issue(mk(1, 5'd8, 1, 5'd2, 1, 5'd9, 1, 0, 0, 0));
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        issue(mk(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0));

        // counter wrap at CNT_W=4
        do_reset();
        for (int k = 0; k < 15; k++) begin
            issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
            issue(mk(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0));
        end
        chk("cnt_max", {28'd0, stall_cnt}, 15);
        issue(mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0));
        issue(mk(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0));
        chk("cnt_wrap", {28'd0, stall_cnt}, 0);

        // random decode traffic over a small register set
        do_reset();
        cur = nop_i();
        for (int n = 0; n < 600; n++) begin
            if (!was_stall) begin
                cur.valid = ($urandom_range(0, 9) != 0);
                cur.rs1 = RW'($urandom_range(0, 3));
                cur.rs2 = RW'($urandom_range(0, 3));
                cur.rd  = RW'($urandom_range(0, 3));
                cur.u1  = ($urandom_range(0, 4) != 0);
                cur.u2  = ($urandom_range(0, 4) != 0);
                cur.st  = ($urandom_range(0, 4) == 0);
                cur.ld  = !cur.st && ($urandom_range(0, 2) == 0);
                cur.rw  = !cur.st && ($urandom_range(0, 4) != 0);
            end
            cur.fl = ($urandom_range(0, 11) == 0);
            cycle(cur);
            if (n == 300) do_reset();
        end

        cycle(nop_i());
        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
